rotary_input_decoder: RTL and testbench
=======================================

// Module: rotary_input_decoder
// PURPOSE
//  Front-end for the alarm's rotary encoder (iA, iB quadrature + SW push switch) feeding the top-level
//  time-setting / menu logic. Synchronises and debounces all three raw pins, decodes full-detent
//  quadrature into one-cycle CW/CCW strobes, and keeps a wrapping setting counter (default 0..59, minutes).
//  Downstream logic (alarm set, VGA display, MP3 trigger) consumes only these clean strobes and counter.
// PARAMETERS
//  DEB_CYCLES  50000  consecutive clk cycles a synced input must differ from its stable value to be accepted
//  POS_W       8      width of o_pos
//  POS_MAX     59     o_pos range 0..POS_MAX, wraps both directions (POS_MAX < 2**POS_W)
//  FAST_CYCLES 2500000 detent-to-detent gap below which acceleration applies (ROT_ACCEL_EN only)
//  ACCEL_STEP  5      o_pos step when accelerating (ROT_ACCEL_EN only; 1 <= ACCEL_STEP <= POS_MAX)
// PORTS
//  clk       in   1      system clock; single clock domain
//  rst       in   1      asynchronous, active-low reset
//  iA        in   1      raw encoder channel A, idle high, asynchronous
//  iB        in   1      raw encoder channel B, idle high, asynchronous
//  SW        in   1      raw push switch, active-low, asynchronous
//  i_pos_clr in   1      synchronous clear of o_pos
//  o_cw      out  1      one-cycle strobe per completed clockwise detent
//  o_ccw     out  1      one-cycle strobe per completed counter-clockwise detent
//  o_press   out  1      one-cycle strobe on debounced press (SW high->low)
//  o_sw      out  1      debounced switch level, 1 = pressed
//  o_pos     out  POS_W  wrapping setting counter
// BEHAVIOUR
//  - Reset (rst=0, async): sync flops and stable values = 1 (idle), debounce counters 0, FSM=IDLE,
//    o_cw=o_ccw=o_press=o_sw=0, o_pos=0. Release mid-rotation: FSM restarts at IDLE, no strobe.
//  - Sync: 2-FF per pin. Debounce per pin: counter clears when synced==stable; else increments; when it
//    reaches DEB_CYCLES-1 while still differing, stable<=synced, counter<=0. Pulses < DEB_CYCLES ignored.
//  - Latency: raw edge -> stable update = DEB_CYCLES+2 clk edges; strobes/o_pos registered, +1 more.
//  - Quadrature FSM on stable {A,B}; detent = 11. CW: 11->01->00->10->11; CCW: 11->10->00->01->11.
//    States IDLE, CW1(01), CW2(00), CW3(10), CCW1(10), CCW2(00), CCW3(01).
//    Forward step advances; backward step (e.g. CW2 sees 01) returns to previous state; 11 from any
//    state -> IDLE; o_cw only on CW3->11, o_ccw only on CCW3->11. Same-cycle change of both A and B
//    (illegal jump) -> IDLE, no strobe. o_cw and o_ccw never high together.
//  - Switch: o_sw = ~stable_SW; o_press high one cycle when stable_SW falls. Held switch: single strobe.
//  - o_pos: on o_cw +step, on o_ccw -step, modulo POS_MAX+1 (POS_MAX+step -> step-1, 0-step -> POS_MAX+1-step).
//    i_pos_clr has priority over a same-cycle step: o_pos<=0, strobe still emitted.
// CONFIGURATION
//  ROT_ACCEL_EN defined: free-running gap counter (saturating at FAST_CYCLES) cleared on each strobe;
//    if gap < FAST_CYCLES at strobe, step = ACCEL_STEP, else 1. First detent after reset uses step 1.
//    Direction change always uses step 1. Strobe timing unchanged.
//  ROT_ACCEL_EN undefined: step always 1; gap counter, FAST_CYCLES, ACCEL_STEP logic absent.
// STRUCTURE
//  - Package rotary_pkg: FSM state encoding localparams (3-bit), detent code 2'b11, step-select helper.
//  - Sub-module rotary_debounce (one pin: 2-FF sync + counter + stable reg, param DEB_CYCLES, reset
//    value 1) instantiated for iA, iB, SW. FSM, press edge detect and o_pos counter in this module.
// TESTING  (bench params DEB_CYCLES=4, POS_MAX=59, FAST_CYCLES=100, ACCEL_STEP=5)
//  - Assert rst=0 mid-traffic -> all strobes 0, o_sw=0, o_pos=0 immediately; after release no strobe.
//  - Full CW sequence, each phase held 10 cycles -> exactly one o_cw pulse, DEB_CYCLES+3 edges after
//    final 10->11 raw edge; o_pos 0->1; o_ccw never high.
//  - From reset, full CCW sequence -> one o_ccw, o_pos 0->59; then CW -> o_pos 59->0.
//  - 3-cycle low glitch on iA, and partial 11->01->00->01->11 -> no strobe, o_pos unchanged.
//  - SW low 20 cycles, 2-cycle bounce high, low again -> one o_press, o_sw=1; i_pos_clr with o_cw same
//    cycle (o_pos=7) -> o_pos=0.
//  - ROT_ACCEL_EN: two CW detents 50 cycles apart from o_pos=57 -> 58 then 3 (57+1, then +5 wraps);
//    gap 200 cycles -> step 1; without macro both steps are 1.

Source files
------------

// File: rtl/rotary_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rotary_pkg : shared types and helpers for the rotary encoder front-end
// Rev 1.0
// ----------------------------------------------------------------------------
package rotary_pkg;

  localparam logic [2:0] C_ST_IDLE = 3'd0;
  localparam logic [2:0] C_ST_CW1  = 3'd1;
  localparam logic [2:0] C_ST_CW2  = 3'd2;
  localparam logic [2:0] C_ST_CW3  = 3'd3;
  localparam logic [2:0] C_ST_CCW1 = 3'd4;
  localparam logic [2:0] C_ST_CCW2 = 3'd5;
  localparam logic [2:0] C_ST_CCW3 = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = C_ST_IDLE,
    ST_CW1  = C_ST_CW1,
    ST_CW2  = C_ST_CW2,
    ST_CW3  = C_ST_CW3,
    ST_CCW1 = C_ST_CCW1,
    ST_CCW2 = C_ST_CCW2,
    ST_CCW3 = C_ST_CCW3
  } rot_state_t;

  localparam logic [1:0] C_DETENT = 2'b11;

  // Accelerated step only for a repeat of the previous direction arriving quickly.
  function automatic logic accel_sel(input logic have_last, input logic same_dir,
                                     input logic fast);
    return have_last & same_dir & fast;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rotary_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rotary_debounce : 2-FF synchroniser plus counter debouncer for one idle-high pin
// Rev 1.0
// ----------------------------------------------------------------------------
module rotary_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/rotary_input_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rotary_input_decoder : debounced quadrature/switch decoder with wrapping counter
// Optional acceleration enabled by defining ROT_ACCEL_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module rotary_input_decoder
  import rotary_pkg::*;
#(
  parameter int DEB_CYCLES  = 50000,
  parameter int POS_W       = 8,
  parameter int POS_MAX     = 59,
  parameter int FAST_CYCLES = 2500000,
  parameter int ACCEL_STEP  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iA,
  input  logic             iB,
  input  logic             SW,
  input  logic             i_pos_clr,
  output logic             o_cw,
  output logic             o_ccw,
  output logic             o_press,
  output logic             o_sw,
  output logic [POS_W-1:0] o_pos
);

  localparam int C_EXT_W = POS_W + 1;
  localparam logic [C_EXT_W-1:0] C_MOD = C_EXT_W'(POS_MAX + 1);

  if (ACCEL_STEP < 1 || ACCEL_STEP > POS_MAX || FAST_CYCLES < 1) begin : g_bad_param
    $error("rotary_input_decoder: ACCEL_STEP/FAST_CYCLES out of range");
  end

  logic       w_a;
  logic       w_b;
  logic       w_sw_st;
  logic [1:0] w_ab;

  rotary_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk(clk), .rst(rst), .i_raw(iA), .o_stable(w_a));
  rotary_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk(clk), .rst(rst), .i_raw(iB), .o_stable(w_b));
  rotary_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw (
    .clk(clk), .rst(rst), .i_raw(SW), .o_stable(w_sw_st));

  assign w_ab = {w_a, w_b};

  rot_state_t r_state;
  logic [1:0] r_ab_prev;
  logic       r_sw_prev;
  rot_state_t w_state_nxt;
  logic       w_cw_hit;
  logic       w_ccw_hit;

  // Any code pair not listed under a state is a two-bit jump and aborts the detent.
  always_comb begin
    w_state_nxt = r_state;
    w_cw_hit    = 1'b0;
    w_ccw_hit   = 1'b0;
    if (w_ab == C_DETENT) begin
      w_state_nxt = ST_IDLE;
      w_cw_hit    = (r_state == ST_CW3);
      w_ccw_hit   = (r_state == ST_CCW3);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_ab_prev == C_DETENT && w_ab == 2'b01)      w_state_nxt = ST_CW1;
          else if (r_ab_prev == C_DETENT && w_ab == 2'b10) w_state_nxt = ST_CCW1;
        end
        ST_CW1:  if (w_ab == 2'b00) w_state_nxt = ST_CW2;
                 else if (w_ab == 2'b10) w_state_nxt = ST_IDLE;
        ST_CW2:  if (w_ab == 2'b10) w_state_nxt = ST_CW3;
                 else if (w_ab == 2'b01) w_state_nxt = ST_CW1;
        ST_CW3:  if (w_ab == 2'b00) w_state_nxt = ST_CW2;
                 else if (w_ab == 2'b01) w_state_nxt = ST_IDLE;
        ST_CCW1: if (w_ab == 2'b00) w_state_nxt = ST_CCW2;
                 else if (w_ab == 2'b01) w_state_nxt = ST_IDLE;
        ST_CCW2: if (w_ab == 2'b01) w_state_nxt = ST_CCW3;
                 else if (w_ab == 2'b10) w_state_nxt = ST_CCW1;
        ST_CCW3: if (w_ab == 2'b00) w_state_nxt = ST_CCW2;
                 else if (w_ab == 2'b10) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  logic [POS_W-1:0] w_step;

`ifdef ROT_ACCEL_EN
  localparam int GAP_W = $clog2(FAST_CYCLES + 1);
  localparam logic [GAP_W-1:0] C_GAP_SAT = GAP_W'(FAST_CYCLES);

  logic [GAP_W-1:0] r_gap;
  logic             r_have_last;
  logic             r_last_cw;

  assign w_step = accel_sel(r_have_last, r_last_cw == w_cw_hit, r_gap < C_GAP_SAT)
                  ? POS_W'(ACCEL_STEP) : POS_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap       <= '0;
      r_have_last <= 1'b0;
      r_last_cw   <= 1'b0;
    end else if (w_cw_hit || w_ccw_hit) begin
      r_gap       <= '0;
      r_have_last <= 1'b1;
      r_last_cw   <= w_cw_hit;
    end else if (r_gap != C_GAP_SAT) begin
      r_gap <= r_gap + 1'b1;
    end
  end
`else
  assign w_step = POS_W'(1);
`endif

  logic [C_EXT_W-1:0] w_up_sum;
  logic [POS_W-1:0]   w_pos_up;
  logic [POS_W-1:0]   w_pos_dn;

  assign w_up_sum = {1'b0, o_pos} + {1'b0, w_step};
  assign w_pos_up = (w_up_sum >= C_MOD) ? POS_W'(w_up_sum - C_MOD) : POS_W'(w_up_sum);
  assign w_pos_dn = (o_pos < w_step) ? POS_W'({1'b0, o_pos} + C_MOD - {1'b0, w_step})
                                     : (o_pos - w_step);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_ab_prev <= C_DETENT;
      r_sw_prev <= 1'b1;
      o_cw      <= 1'b0;
      o_ccw     <= 1'b0;
      o_press   <= 1'b0;
      o_sw      <= 1'b0;
      o_pos     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ab_prev <= w_ab;
      r_sw_prev <= w_sw_st;
      o_cw      <= w_cw_hit;
      o_ccw     <= w_ccw_hit;
      o_press   <= r_sw_prev & ~w_sw_st;
      o_sw      <= ~w_sw_st;
      if (i_pos_clr)      o_pos <= '0;
      else if (w_cw_hit)  o_pos <= w_pos_up;
      else if (w_ccw_hit) o_pos <= w_pos_dn;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rotary_input_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rotary_input_decoder : directed self-checking bench (DEB_CYCLES=4, POS_MAX=59)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rotary_input_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iA = 1'b1;
  logic       iB = 1'b1;
  logic       SW = 1'b1;
  logic       i_pos_clr = 1'b0;
  logic       o_cw, o_ccw, o_press, o_sw;
  logic [7:0] o_pos;

  int checks = 0;
  int failures = 0;
  int n_cw = 0, n_ccw = 0, n_press = 0, n_both = 0;
  int c0, cc0, p0;

  rotary_input_decoder #(
    .DEB_CYCLES(4), .POS_W(8), .POS_MAX(59), .FAST_CYCLES(100), .ACCEL_STEP(5)
  ) dut (
    .clk(clk), .rst(rst), .iA(iA), .iB(iB), .SW(SW), .i_pos_clr(i_pos_clr),
    .o_cw(o_cw), .o_ccw(o_ccw), .o_press(o_press), .o_sw(o_sw), .o_pos(o_pos)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (o_cw)          n_cw++;
      if (o_ccw)         n_ccw++;
      if (o_press)       n_press++;
      if (o_cw && o_ccw) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ab, input int n);
    iA = ab[1];
    iB = ab[0];
    tick(n);
  endtask

  task automatic rot(input bit cw, input int hold);
    if (cw) begin
      drive(2'b01, hold); drive(2'b00, hold); drive(2'b10, hold); drive(2'b11, hold);
    end else begin
      drive(2'b10, hold); drive(2'b00, hold); drive(2'b01, hold); drive(2'b11, hold);
    end
  endtask

  initial begin
    // reset state
    #23;
    chk("rst_cw", o_cw, 0);
    chk("rst_ccw", o_ccw, 0);
    chk("rst_press", o_press, 0);
    chk("rst_sw", o_sw, 0);
    chk("rst_pos", o_pos, 0);
    tick(1);
    rst = 1'b1;
    tick(5);

    // full CW detent with exact strobe timing
    drive(2'b01, 10); drive(2'b00, 10); drive(2'b10, 10);
    iA = 1'b1; iB = 1'b1;
    tick(6);
    chk("cw_early", o_cw, 0);
    tick(1);
    chk("cw_edge", o_cw, 1);
    tick(1);
    chk("cw_width", o_cw, 0);
    tick(7);
    chk("cw_count", n_cw, 1);
    chk("cw_no_ccw", n_ccw, 0);
    chk("cw_pos", o_pos, 1);

    // asynchronous reset in the middle of a detent with switch held
    drive(2'b01, 10); drive(2'b00, 10);
    SW = 1'b0;
    tick(10);
    chk("pre_rst_sw", o_sw, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_pos", o_pos, 0);
    chk("arst_sw", o_sw, 0);
    chk("arst_cw", o_cw, 0);
    chk("arst_press", o_press, 0);
    SW = 1'b1;
    tick(2);
    rst = 1'b1;
    c0 = n_cw; cc0 = n_ccw;
    drive(2'b00, 10); drive(2'b10, 10); drive(2'b11, 10);
    chk("rel_no_strobe", n_cw + n_ccw, c0 + cc0);

    // CCW wraps down, CW wraps up
    rot(1'b0, 10);
    chk("ccw_count", n_ccw, cc0 + 1);
    chk("ccw_wrap", o_pos, 59);
    rot(1'b1, 10);
    chk("cw_wrap", o_pos, 0);

    // glitch and partial rotation
    c0 = n_cw; cc0 = n_ccw;
    iA = 1'b0; tick(3); iA = 1'b1; tick(10);
    drive(2'b01, 10); drive(2'b00, 10); drive(2'b01, 10); drive(2'b11, 10);
    chk("glitch_strobes", n_cw + n_ccw, c0 + cc0);
    chk("glitch_pos", o_pos, 0);

    // switch with bounce
    p0 = n_press;
    SW = 1'b0; tick(20);
    chk("sw_held", o_sw, 1);
    SW = 1'b1; tick(2);
    SW = 1'b0; tick(20);
    chk("press_once", n_press, p0 + 1);
    chk("sw_still", o_sw, 1);
    SW = 1'b1; tick(20);
    chk("sw_release", o_sw, 0);
    chk("press_after_rel", n_press, p0 + 1);

    // clear colliding with a step
    repeat (7) rot(1'b1, 30);
    chk("pos_seven", o_pos, 7);
    c0 = n_cw;
    drive(2'b01, 30); drive(2'b00, 30); drive(2'b10, 30);
    iA = 1'b1; iB = 1'b1;
    tick(5);
    i_pos_clr = 1'b1;
    tick(2);
    chk("clr_strobe", o_cw, 1);
    tick(1);
    i_pos_clr = 1'b0;
    tick(25);
    chk("clr_pos", o_pos, 0);
    chk("clr_count", n_cw, c0 + 1);

    // acceleration (or plain stepping without it)
    repeat (3) rot(1'b0, 30);
    chk("pos_57", o_pos, 57);
    rot(1'b1, 30);
    chk("acc_first", o_pos, 58);
    rot(1'b1, 13);
`ifdef ROT_ACCEL_EN
    chk("acc_fast", o_pos, 3);
`else
    chk("acc_fast", o_pos, 59);
`endif
    rot(1'b1, 50);
`ifdef ROT_ACCEL_EN
    chk("acc_slow", o_pos, 4);
`else
    chk("acc_slow", o_pos, 0);
`endif

    chk("never_both", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
